// File: rtl/mdu_unit_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: operation codes
// (also decoded by the hazard control unit), default latencies and FSM states.
package mdu_unit_pkg;

   // MDU operation encodings carried down the pipeline with each instruction
   localparam logic [3:0] MDU_NONE  = 4'd0;
   localparam logic [3:0] MDU_MULT  = 4'd1;
   localparam logic [3:0] MDU_MULTU = 4'd2;
   localparam logic [3:0] MDU_DIV   = 4'd3;
   localparam logic [3:0] MDU_DIVU  = 4'd4;
   localparam logic [3:0] MDU_MFHI  = 4'd5;
   localparam logic [3:0] MDU_MFLO  = 4'd6;
   localparam logic [3:0] MDU_MTHI  = 4'd7;
   localparam logic [3:0] MDU_MTLO  = 4'd8;

   // Default busy latencies
   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   // Busy-cycle counter width; latencies up to 255 cycles
   localparam int CNT_W = 8;

   // FSM state encoding
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   // A 64-bit result split the way it lands in HI/LO
   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
   } hilo_t;

   // True for the operations that occupy the unit for several cycles
   function automatic logic is_start_op(input logic [3:0] op);
      return (op >= MDU_MULT) && (op <= MDU_DIVU);
   endfunction

endpackage

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit. Owns HI/LO, runs mult/multu/div/divu with a
// fixed busy latency and answers the start/busy stall handshake. The full
// result is computed in the start cycle and held until the commit edge.
module mdu_unit
   import mdu_unit_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  mdu_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        req,
   output logic        start,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] mdu_out
);

   logic [0:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      hi_tmp;
   logic [31:0]      lo_tmp;
   logic             no_commit;
   hilo_t            res;
   logic             is_div;
   logic             div_zero;

   // Signed 32x32 -> 64 product
   function automatic hilo_t mul_s(input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] ax;
      logic signed [63:0] bx;
      logic signed [63:0] p;
      ax = {{32{a[31]}}, a};
      bx = {{32{b[31]}}, b};
      p  = ax * bx;
      return hilo_t'(p);
   endfunction

   // Unsigned 32x32 -> 64 product
   function automatic hilo_t mul_u(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      p = {32'd0, a} * {32'd0, b};
      return hilo_t'(p);
   endfunction

   // Signed divide, truncating quotient; 33-bit width keeps -2^31/-1 defined.
   // A zero divisor is replaced so the datapath never sees X; that result is
   // never committed.
   function automatic hilo_t div_s(input logic [31:0] a, input logic [31:0] b);
      logic signed [32:0] ax;
      logic signed [32:0] bx;
      logic signed [32:0] q;
      logic signed [32:0] r;
      hilo_t              o;
      ax = {a[31], a};
      bx = (b == 32'd0) ? 33'sd1 : {b[31], b};
      q  = ax / bx;
      r  = ax % bx;
      o.hi = r[31:0];
      o.lo = q[31:0];
      return o;
   endfunction

   // Unsigned divide with the same zero-divisor guard
   function automatic hilo_t div_u(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] d;
      hilo_t       o;
      d    = (b == 32'd0) ? 32'd1 : b;
      o.hi = a % d;
      o.lo = a / d;
      return o;
   endfunction

   assign is_div   = (mdu_op == MDU_DIV) || (mdu_op == MDU_DIVU);
   assign div_zero = is_div && (B == 32'd0);
   assign start    = is_start_op(mdu_op) && !req && (state == ST_IDLE);

   // Full result of the operation presented in E this cycle
   always_comb begin
      res = '0;
      case (mdu_op)
         MDU_MULT:  res = mul_s(A, B);
         MDU_MULTU: res = mul_u(A, B);
         MDU_DIV:   res = div_s(A, B);
         MDU_DIVU:  res = div_u(A, B);
         default:   res = '0;
      endcase
   end

   // HI/LO read-back for mfhi/mflo
   always_comb begin
      mdu_out = 32'd0;
      case (mdu_op)
         MDU_MFHI: mdu_out = hi;
         MDU_MFLO: mdu_out = lo;
         default:  mdu_out = 32'd0;
      endcase
   end

   // Busy FSM, result holding and HI/LO updates; commit outranks mthi/mtlo
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_IDLE;
         busy      <= 1'b0;
         cnt       <= '0;
         hi_tmp    <= 32'd0;
         lo_tmp    <= 32'd0;
         no_commit <= 1'b0;
         hi        <= 32'd0;
         lo        <= 32'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  hi_tmp    <= res.hi;
                  lo_tmp    <= res.lo;
                  no_commit <= div_zero;
                  cnt       <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                  busy      <= 1'b1;
                  state     <= ST_BUSY;
               end else if (!req) begin
                  if (mdu_op == MDU_MTHI) hi <= A;
                  if (mdu_op == MDU_MTLO) lo <= A;
               end
            end
            default: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  if (!no_commit) begin
                     hi <= hi_tmp;
                     lo <= lo_tmp;
                  end
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: the stimulus process drives one cycle at a
// time, predicts that cycle's outputs from a behavioural HI/LO model and
// queues them; the monitor pops and compares on every falling edge.
module tb_mdu_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  mdu_op;
   logic [31:0] A;
   logic [31:0] B;
   logic        req;
   logic        start;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] mdu_out;

   always #5 clk = ~clk;

   mdu_unit dut (
      .clk     (clk),
      .reset   (reset),
      .mdu_op  (mdu_op),
      .A       (A),
      .B       (B),
      .req     (req),
      .start   (start),
      .busy    (busy),
      .hi      (hi),
      .lo      (lo),
      .mdu_out (mdu_out)
   );

   typedef struct packed {
      logic        start;
      logic        busy;
      logic [31:0] hi;
      logic [31:0] lo;
      logic [31:0] mout;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   bit   mon_en = 0;

   // Reference model state
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;
   logic [31:0] p_hi = 32'd0;
   logic [31:0] p_lo = 32'd0;
   int          m_left = 0;
   bit          m_nc = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Monitor: compare each cycle's outputs against the queued prediction
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (q.size() == 0) begin
            n_chk++;
            $display("FAIL scoreboard_empty: got no prediction expected one (t=%0t)", $time);
         end else begin
            e = q.pop_front();
            check32("start",   {31'd0, start}, {31'd0, e.start});
            check32("busy",    {31'd0, busy},  {31'd0, e.busy});
            check32("hi",      hi,             e.hi);
            check32("lo",      lo,             e.lo);
            check32("mdu_out", mdu_out,        e.mout);
         end
      end
   end

   // Architectural result of a multi-cycle op, straight from the ISA rules
   task automatic compute(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb, sp;
      longint unsigned ua, ub, up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      m_nc = 0;
      case (op)
         4'd1: begin sp = sa * sb; p_hi = sp[63:32]; p_lo = sp[31:0]; end
         4'd2: begin up = ua * ub; p_hi = up[63:32]; p_lo = up[31:0]; end
         4'd3: begin
            if (b == 32'd0) m_nc = 1;
            else begin
               sp = sa / sb; p_lo = sp[31:0];
               sp = sa % sb; p_hi = sp[31:0];
            end
         end
         default: begin
            if (b == 32'd0) m_nc = 1;
            else begin
               up = ua / ub; p_lo = up[31:0];
               up = ua % ub; p_hi = up[31:0];
            end
         end
      endcase
   endtask

   // Drive one cycle, queue its predicted outputs, advance the model past the edge
   task automatic step(input logic rst_n, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic rq);
      exp_t e;
      bit   st;
      @(posedge clk);
      #2;
      reset = rst_n; mdu_op = op; A = a; B = b; req = rq;
      st = (op >= 4'd1) && (op <= 4'd4) && !rq && (m_left == 0);
      e.start = st;
      e.busy  = (m_left != 0);
      e.hi    = m_hi;
      e.lo    = m_lo;
      e.mout  = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
      q.push_back(e);
      mon_en = 1;
      if (!rst_n) begin
         m_hi = 32'd0; m_lo = 32'd0; m_left = 0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0 && !m_nc) begin m_hi = p_hi; m_lo = p_lo; end
      end else if (st) begin
         compute(op, a, b);
         m_left = (op <= 4'd2) ? 5 : 10;
      end else if (!rq) begin
         if (op == 4'd7) m_hi = a;
         if (op == 4'd8) m_lo = a;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 4'd0, 32'd0, 32'd0, 1'b0);
   endtask

   function automatic logic [31:0] rand_val();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      reset = 1'b0; mdu_op = 4'd0; A = 32'd0; B = 32'd0; req = 1'b0;
      @(posedge clk);
      step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
      step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
      idle(1);

      // mult / multu of 0xFFFFFFFF by 2
      step(1'b1, 4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
      idle(6);
      check32("mult_hi", hi, 32'hFFFF_FFFF);
      check32("mult_lo", lo, 32'hFFFF_FFFE);
      step(1'b1, 4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
      idle(6);
      check32("multu_hi", hi, 32'h0000_0001);
      check32("multu_lo", lo, 32'hFFFF_FFFE);

      // div -7 / 2
      step(1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
      idle(11);
      check32("div_hi", hi, 32'hFFFF_FFFF);
      check32("div_lo", lo, 32'hFFFF_FFFD);

      // divu by zero leaves HI/LO alone
      step(1'b1, 4'd7, 32'h1234_5678, 32'd0, 1'b0);
      step(1'b1, 4'd8, 32'h1234_5678, 32'd0, 1'b0);
      step(1'b1, 4'd4, 32'd99, 32'd0, 1'b0);
      idle(11);
      check32("divz_hi", hi, 32'h1234_5678);
      check32("divz_lo", lo, 32'h1234_5678);

      // mthi then mfhi; mthi under req is dropped
      step(1'b1, 4'd7, 32'hDEAD_BEEF, 32'd0, 1'b0);
      step(1'b1, 4'd5, 32'd0, 32'd0, 1'b0);
      #1 check32("mfhi_out", mdu_out, 32'hDEAD_BEEF);
      step(1'b1, 4'd7, 32'h0000_0001, 32'd0, 1'b1);
      idle(1);
      check32("mthi_req_hi", hi, 32'hDEAD_BEEF);

      // mult under req never starts
      step(1'b1, 4'd1, 32'd3, 32'd4, 1'b1);
      idle(2);

      // req during a div in flight; ops presented while busy are ignored
      step(1'b1, 4'd3, 32'd100, 32'd7, 1'b0);
      step(1'b1, 4'd0, 32'd0, 32'd0, 1'b1);
      step(1'b1, 4'd7, 32'hAAAA_AAAA, 32'd0, 1'b0);
      step(1'b1, 4'd1, 32'd5, 32'd5, 1'b1);
      step(1'b1, 4'd2, 32'd5, 32'd5, 1'b0);
      idle(7);
      check32("div_req_lo", lo, 32'd14);
      check32("div_req_hi", hi, 32'd2);

      // reset in the third busy cycle of a div, then a normal mult
      step(1'b1, 4'd3, 32'd50, 32'd3, 1'b0);
      idle(2);
      step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
      idle(1);
      check32("rst_busy", {31'd0, busy}, 32'd0);
      check32("rst_hi", hi, 32'd0);
      step(1'b1, 4'd1, 32'd6, 32'd7, 1'b0);
      idle(6);
      check32("post_rst_lo", lo, 32'd42);

      // Randomized traffic, ops allowed at any time
      for (int i = 0; i < 600; i++) begin
         logic [3:0] op;
         op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
         step(($urandom_range(0, 60) != 0), op, rand_val(), rand_val(),
              ($urandom_range(0, 7) == 0));
      end
      idle(12);

      @(negedge clk);
      #1;
      mon_en = 0;
      n_chk++;
      if (q.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drain: got %0d left expected 0", q.size());
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   // Hard time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Execute-stage multiply/divide unit of the P7 five-stage MIPS pipeline.
- It is the responder side of the start/busy handshake that the hazard control unit consumes to stall MDU instructions in D.
- It owns the HI/LO registers and executes mult/multu/div/divu with fixed multi-cycle latency.
- It also handles mthi/mtlo/mfhi/mflo, and suppresses state changes when the CP0 exception/interrupt request (req) is active.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu.
- DIV_CYCLES, 10, busy cycles for div/divu.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- mdu_op  input  4  E-stage MDU operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, others treated as none.
- A  input  32  E-stage rs operand, post-forwarding.
- B  input  32  E-stage rt operand, post-forwarding.
- req  input  1  exception/interrupt taken this cycle; blocks every E-stage MDU state change.
- start  output  1  combinational; high when mdu_op is 1..4, req=0 and state is IDLE.
- busy  output  1  registered; high while an operation is in flight.
- hi  output  32  architectural HI register.
- lo  output  32  architectural LO register.
- mdu_out  output  32  combinational; hi when mdu_op=5, lo when mdu_op=6, else 0.

Behaviour:
- Reset (reset=0 at posedge): state IDLE, busy=0, hi=lo=0, counter=0, temporaries=0. Reset wins over every other event, including mid-operation; any in-flight result is discarded.
- FSM states: IDLE, BUSY.
- IDLE -> BUSY on the edge where start=1:
  - Latch the full result into hi_tmp/lo_tmp.
  - Load counter = MULT_CYCLES or DIV_CYCLES by op.
  - Set busy=1.
- BUSY: counter decrements each edge.
  - On the edge where counter=1: hi<=hi_tmp, lo<=lo_tmp (if a result is pending), busy<=0, state IDLE.
  - Timing: start seen in cycle t gives busy=1 in cycles t+1..t+N, new HI/LO visible from cycle t+N+1, where N is the op latency.
- Arithmetic:
  - mult: signed 32x32 -> 64. multu: unsigned. {hi,lo} = product.
  - div: signed, lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - divu: unsigned.
- Divide by zero (B=0): operation still occupies DIV_CYCLES busy cycles, but HI/LO are left unchanged at commit. A no-commit flag is latched at start.
- mthi/mtlo: in IDLE with req=0, hi<=A (resp. lo<=A) at the next edge; no busy.
- mfhi/mflo: purely combinational read; no state change.
- req=1:
  - start forced 0; mthi/mtlo writes suppressed.
  - An operation already in BUSY continues and commits, since its instruction has already retired past E.
- MDU ops arriving while busy=1: the HCU stalls D on busy|start, so none arrive in normal operation. If mdu_op is nonzero while BUSY, it is ignored (no start, no mthi/mtlo write).
- Simultaneous events:
  - Commit edge coinciding with an mthi/mtlo in E: the commit wins. This cannot occur under correct HCU stalling, but the priority is fixed.
  - Back-to-back ops: a new start is possible in the first IDLE cycle after commit.

Decomposition:
- Shared package: MDUOp encodings (MDU_NONE..MDU_MTLO), MULT_CYCLES/DIV_CYCLES defaults, and the FSM state encoding. The HCU uses the same MDUOp constants.
- No sub-module: the multiply/divide are behavioural 64-bit expressions inside mdu_unit.

Test Plan:
- mult, A=0xFFFFFFFF, B=0x00000002 -> start=1 for one cycle, busy=1 for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- multu, same operands -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
- div, A=0xFFFFFFF9 (-7), B=2 -> 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu with B=0 after hi=lo=0x12345678 -> 10 busy cycles, hi/lo remain 0x12345678.
- mthi A=0xDEADBEEF, then mfhi -> hi=0xDEADBEEF next cycle and mdu_out=0xDEADBEEF. The same mthi with req=1 -> hi unchanged, start=0.
- mult with req=1 -> start=0, busy stays 0, hi/lo unchanged. req=1 during BUSY of a prior div -> div still commits on schedule.
- reset=0 asserted in the 3rd busy cycle of a div -> next cycle busy=0, hi=lo=0. A following mult behaves normally (5 busy cycles).
